// File: rtl/vec_pkg.sv
// vec_pkg: shared types and constants for the vector sequencer
package vec_pkg;
    localparam int OP_W       = 4;
    localparam int ADDR_W_DEF = 16;
    localparam int LEN_W_DEF  = 8;
    typedef enum logic [2:0] {IDLE, READ_A, READ_B, WRITE, DONE} state_t;
endpackage

// File: rtl/vector_sequencer.sv
// vector_sequencer: walks len elements doing read A, optional read B, write result over one memory port
module vector_sequencer
    import vec_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              unary,
    input  logic [OP_W-1:0]   opIn,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic              memReady,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRead,
    output logic              memWrite,
    output logic              loadA,
    output logic              loadB,
    output logic [OP_W-1:0]   aluOp,
    output logic              busy,
    output logic              done
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pa_q, pa_d, pb_q, pb_d, pd_q, pd_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              unary_q, unary_d;
    logic [OP_W-1:0]   op_q, op_d;
    // next state: latch the op at start, advance pointers when an element's write completes
    always_comb begin
        state_d = state_q;
        pa_d    = pa_q;
        pb_d    = pb_q;
        pd_d    = pd_q;
        rem_d   = rem_q;
        unary_d = unary_q;
        op_d    = op_q;
        case (state_q)
            IDLE: if (start) begin
                pa_d    = srcA;
                pb_d    = srcB;
                pd_d    = dst;
                rem_d   = len;
                unary_d = unary;
                op_d    = opIn;
                state_d = (len == '0) ? DONE : READ_A;
            end
            READ_A: if (memReady) state_d = unary_q ? WRITE : READ_B;
            READ_B: if (memReady) state_d = WRITE;
            WRITE: if (memReady) begin
                pa_d    = pa_q + ADDR_W'(1);
                pb_d    = pb_q + ADDR_W'(1);
                pd_d    = pd_q + ADDR_W'(1);
                rem_d   = rem_q - LEN_W'(1);
                state_d = (rem_q == LEN_W'(1)) ? DONE : READ_A;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // outputs: requests and address from state only; operand loads qualified by memReady
    always_comb begin
        memRead  = (state_q == READ_A) || (state_q == READ_B);
        memWrite = state_q == WRITE;
        memAddr  = (state_q == READ_A) ? pa_q :
                   (state_q == READ_B) ? pb_q :
                   (state_q == WRITE)  ? pd_q : '0;
        loadA    = (state_q == READ_A) && memReady;
        loadB    = (state_q == READ_B) && memReady;
        busy     = state_q != IDLE;
        done     = state_q == DONE;
        aluOp    = op_q;
    end
    // state registers; reset abandons any op in flight and clears everything
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pa_q    <= '0;
            pb_q    <= '0;
            pd_q    <= '0;
            rem_q   <= '0;
            unary_q <= 1'b0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            pd_q    <= pd_d;
            rem_q   <= rem_d;
            unary_q <= unary_d;
            op_q    <= op_d;
        end
    end
endmodule

// File: tb/tb_vector_sequencer.sv
// tb_vector_sequencer: directed table-driven and hand-sequenced checks of vector_sequencer
module tb_vector_sequencer;
    logic        clock = 0, reset = 1, start = 0, unary = 0, memReady = 0;
    logic [3:0]  opIn = 0;
    logic [15:0] srcA = 0, srcB = 0, dst = 0;
    logic [7:0]  len = 0;
    logic [15:0] memAddr;
    logic        memRead, memWrite, loadA, loadB, busy, done;
    logic [3:0]  aluOp;
    int n_cmp = 0, n_bad = 0;

    vector_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .unary(unary), .opIn(opIn),
        .srcA(srcA), .srcB(srcB), .dst(dst), .len(len), .memReady(memReady),
        .memAddr(memAddr), .memRead(memRead), .memWrite(memWrite), .loadA(loadA),
        .loadB(loadB), .aluOp(aluOp), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic             un;
        logic [3:0]       op;
        logic [15:0]      a, b, d;
        logic [7:0]       ln;
        int               n_acc;
        logic [8:0][15:0] addr;
        logic [8:0]       wr;
        int               done_cyc;
        int               nb;
    } vec_t;

    vec_t tbl[4];
    vec_t fresh;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic un, input logic [3:0] op, input logic [15:0] a, b, d,
                                input logic [7:0] ln, input int n_acc, input logic [8:0][15:0] addr,
                                input logic [8:0] wr, input int done_cyc, input int nb);
        vec_t v;
        v.un = un; v.op = op; v.a = a; v.b = b; v.d = d; v.ln = ln; v.n_acc = n_acc;
        v.addr = addr; v.wr = wr; v.done_cyc = done_cyc; v.nb = nb;
        return v;
    endfunction

    // starts in the current (idle) cycle, returns in the first idle cycle after done
    task automatic run_vec(input vec_t v);
        int idx = 0, nb = 0;
        bit got = 0;
        start = 1; unary = v.un; opIn = v.op; srcA = v.a; srcB = v.b; dst = v.d; len = v.ln; memReady = 1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c == 1) begin
                start = 0; srcA = 16'hDEAD; srcB = 16'hBEEF; dst = 16'hCAFE; len = 8'hFF;
                unary = ~v.un; opIn = ~v.op;
            end
            if (memRead || memWrite) begin
                if (idx < 9) begin
                    chk("addr", memAddr, v.addr[idx]);
                    chk("kind_wr", memWrite, v.wr[idx]);
                end
                chk("rd_wr_excl", memRead & memWrite, 0);
                idx++;
            end
            if (loadB) nb++;
            if (busy) chk("aluOp", aluOp, v.op);
            if (done) begin
                chk("done_cyc", c, v.done_cyc);
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got none expected cycle %0d", v.done_cyc);
        end
        chk("n_acc", idx, v.n_acc);
        chk("loadB_count", nb, v.nb);
        step();
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        tbl[0] = mk(0, 4'h3, 16'h10, 16'h20, 16'h30, 3, 9,
                    {16'h32, 16'h22, 16'h12, 16'h31, 16'h21, 16'h11, 16'h30, 16'h20, 16'h10},
                    9'b100100100, 10, 3);
        tbl[1] = mk(1, 4'h5, 16'h40, 16'h99, 16'h50, 2, 4,
                    {{5{16'h0}}, 16'h51, 16'h41, 16'h50, 16'h40}, 9'b000001010, 5, 0);
        tbl[2] = mk(0, 4'h7, 16'h1, 16'h2, 16'h3, 0, 0, {9{16'h0}}, 9'b0, 1, 0);
        tbl[3] = mk(0, 4'hA, 16'h100, 16'h200, 16'h300, 1, 3,
                    {{6{16'h0}}, 16'h300, 16'h200, 16'h100}, 9'b000000100, 4, 1);
        fresh  = mk(0, 4'hC, 16'h7, 16'h8, 16'h9, 1, 3,
                    {{6{16'h0}}, 16'h9, 16'h8, 16'h7}, 9'b000000100, 4, 1);

        step(); step();
        chk("rst_memAddr", memAddr, 0); chk("rst_memRead", memRead, 0);
        chk("rst_memWrite", memWrite, 0); chk("rst_loadA", loadA, 0);
        chk("rst_loadB", loadB, 0); chk("rst_aluOp", aluOp, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        reset = 0;
        step();

        for (int i = 0; i < 4; i++) run_vec(tbl[i]);
        chk("len0_idle_c2", busy, 0);

        // READ_B stalled two cycles, len 1
        start = 1; unary = 0; opIn = 4'h2; srcA = 16'h60; srcB = 16'h70; dst = 16'h80; len = 1; memReady = 1;
        step(); start = 0; #1;
        chk("stall_c1_addr", memAddr, 16'h60); chk("stall_c1_loadA", loadA, 1);
        step(); memReady = 0; #1;
        chk("stall_c2_addr", memAddr, 16'h70); chk("stall_c2_rd", memRead, 1); chk("stall_c2_loadB", loadB, 0);
        step(); #1;
        chk("stall_c3_addr", memAddr, 16'h70); chk("stall_c3_rd", memRead, 1); chk("stall_c3_loadB", loadB, 0);
        step(); memReady = 1; #1;
        chk("stall_c4_addr", memAddr, 16'h70); chk("stall_c4_loadB", loadB, 1);
        step(); #1;
        chk("stall_c5_wr", memWrite, 1); chk("stall_c5_addr", memAddr, 16'h80);
        step(); #1;
        chk("stall_c6_done", done, 1);
        step(); #1;
        chk("stall_c7_busy", busy, 0);

        // address wrap and start while busy
        start = 1; unary = 0; opIn = 4'h1; srcA = 16'hFFFF; srcB = 16'h10; dst = 16'h20; len = 2;
        step(); start = 0;
        chk("wrap_c1_addr", memAddr, 16'hFFFF);
        step(); start = 1; srcA = 16'h5555; len = 0;
        chk("wrap_c2_addr", memAddr, 16'h10);
        step(); start = 0;
        chk("wrap_c3_addr", memAddr, 16'h20); chk("wrap_c3_wr", memWrite, 1);
        step();
        chk("wrap_c4_addr", memAddr, 16'h0000); chk("wrap_c4_rd", memRead, 1);
        step(); chk("wrap_c5_addr", memAddr, 16'h11);
        step(); chk("wrap_c6_addr", memAddr, 16'h21);
        step(); chk("wrap_c7_done", done, 1); chk("wrap_c7_aluOp", aluOp, 4'h1);
        step(); chk("wrap_c8_busy", busy, 0);

        // reset during element 2 write
        start = 1; unary = 0; opIn = 4'h6; srcA = 16'h1; srcB = 16'h2; dst = 16'h3; len = 3;
        for (int c = 1; c <= 6; c++) begin
            step();
            start = 0;
        end
        chk("rstmid_c6_wr", memWrite, 1); chk("rstmid_c6_addr", memAddr, 16'h4);
        reset = 1;
        step();
        chk("rstmid_memAddr", memAddr, 0); chk("rstmid_memRead", memRead, 0);
        chk("rstmid_memWrite", memWrite, 0); chk("rstmid_loadA", loadA, 0);
        chk("rstmid_loadB", loadB, 0); chk("rstmid_aluOp", aluOp, 0);
        chk("rstmid_busy", busy, 0); chk("rstmid_done", done, 0);
        reset = 0;
        step();
        chk("rstmid_idle_busy", busy, 0); chk("rstmid_idle_rd", memRead | memWrite, 0);
        run_vec(fresh);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vector_sequencer.md
# vector_sequencer

Multi-cycle element sequencer for memory-to-memory vector instructions. On `start`, it walks `len` elements: read operand A, optionally read operand B, then write the result, one element at a time. It drives the single shared data-memory port and the operand-latch enables of the vector datapath. It sits between `Control` (which decodes the opcode and supplies `aluOp`) and the memory/ALU datapath.

## Interface
Parameters:
- `ADDR_W`, 16, memory address width (word addresses)
- `LEN_W`, 8, vector length width

Ports:
- `clock`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin vector op; sampled only in IDLE
- `unary`  in  1  op has one source; READ_B is skipped; latched at start
- `opIn`  in  4  ALU opcode from `Control`; latched at start
- `srcA`, `srcB`, `dst`  in  ADDR_W  base word addresses; latched at start
- `len`  in  LEN_W  element count; latched at start
- `memReady`  in  1  memory access complete this cycle
- `memAddr`  out  ADDR_W  memory address
- `memRead`  out  1  read request
- `memWrite`  out  1  write request
- `loadA`  out  1  latch memory read data into operand A register
- `loadB`  out  1  latch memory read data into operand B register
- `aluOp`  out  4  latched opcode, held stable while busy
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, READ_A, READ_B, WRITE, DONE.
- IDLE:
  - `start` latches `srcA`/`srcB`/`dst` into pointers `pA`/`pB`/`pD`, `len` into `remaining`, and also latches `unary` and `opIn`.
  - Next state is READ_A, or DONE if `len`==0. A `len`==0 op performs no memory access.
- READ_A:
  - `memRead`=1, `memAddr`=`pA`.
  - On `memReady`: `loadA`=1 in that same cycle. Next state is READ_B, or WRITE if `unary`.
- READ_B:
  - `memRead`=1, `memAddr`=`pB`.
  - On `memReady`: `loadB`=1. Next state is WRITE.
- WRITE:
  - `memWrite`=1, `memAddr`=`pD`.
  - On `memReady`: `pA`, `pB`, `pD` each increment by 1 and `remaining` decrements by 1.
  - Next state is DONE if `remaining`==1, else READ_A.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Without `memReady`, the state and all request outputs hold. `memRead` and `memWrite` are never both high.
- Pointers wrap modulo 2^ADDR_W with no error flag.
- `start` while `busy` is ignored. Input changes after start have no effect.
- `reset` (any state, including mid-op) forces IDLE, clears the pointers and `remaining`, and drives all outputs to 0. No further memory request is issued after the reset cycle.

## Timing
- Reset values: `memAddr`=0, `memRead`=0, `memWrite`=0, `loadA`=0, `loadB`=0, `aluOp`=0, `busy`=0, `done`=0.
- Output classes:
  - `memAddr`, `memRead`, `memWrite`, `busy`, `done`, `aluOp` are functions of registered state only (Moore).
  - `loadA` and `loadB` are state AND `memReady` (Mealy), and are valid in the cycle the access completes.
- Cycle numbering, with `memReady` tied high and `start` at cycle 0:
  - READ_A occupies cycle 1.
  - Element k (1-based) writes in cycle 3k, or 2k if unary.
  - `done` is high at cycle 3·len+1, or 2·len+1 if unary; `busy` falls the following cycle.
- A `len`==0 start gives `done` at cycle 1.
- Each memory wait cycle adds exactly one cycle of latency.
- A new `start` is accepted in the first IDLE cycle after DONE.

## Structure
- Shared package `vec_pkg` holds:
  - the state enum (IDLE, READ_A, READ_B, WRITE, DONE)
  - the ALU opcode width constant (4)
  - default `ADDR_W` and `LEN_W`
- A single module with no sub-module: the pointers and counter are simple registers, and the FSM is one next-state block plus one output block.

## Test plan
- Binary op, `len`=3, `srcA`=0x10, `srcB`=0x20, `dst`=0x30, `memReady` high -> `memAddr` sequence 10,20,30,11,21,31,12,22,32; `done` at cycle 10.
- Unary op, `len`=2, `srcA`=0x40, `dst`=0x50 -> addresses 40,50,41,51; `loadB` never high; `done` at cycle 5.
- `len`=0 -> no `memRead`/`memWrite`; `done` at cycle 1; back to IDLE at cycle 2.
- `memReady` withheld 2 cycles in READ_B of element 1, `len`=1 -> `memAddr`=`srcB` held 3 cycles; `loadB` only in the third; `done` at cycle 6.
- `srcA`=0xFFFF, `len`=2 -> second A read at address 0x0000; `start` pulsed mid-op ignored.
- `reset` asserted in WRITE of element 2 -> next cycle all outputs 0 and IDLE; a fresh `start` with `len`=1 completes normally.
